leaf_out_arbiter: RTL
=====================

Name: leaf_out_arbiter

Overview:
- Shares the single leaf-to-BFT output packet port among NUM_SRC packet requesters, e.g. stream flow-control outputs, config readback and RISC-V status.
- Grants are round-robin; each winning packet is registered onto dout_leaf_interface2bft.
- The registered packet is held and re-presented while the BFT asserts resend.
- Sits between the leaf's producer blocks and the leaf interface's BFT output; replaces a hard-wired single stream_in connection.

Parameters:
- PACKET_BITS, 97, packet width; bit PACKET_BITS-1 is the valid bit.
- NUM_SRC, 4, number of requesters (2..8).
- MAX_RETRY, 255, consecutive-resend count that sets stall_err.
- CNT_BITS, 32, width of the sent-packet counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- src_pkt  in  NUM_SRC*PACKET_BITS  requester packets; source i occupies slice [i*PACKET_BITS +: PACKET_BITS]
- src_valid  in  NUM_SRC  requester has a packet
- src_ready  out  NUM_SRC  one-hot-or-zero accept; combinational
- dout_leaf_interface2bft  out  PACKET_BITS  registered packet to BFT
- resend  in  1  BFT rejected the packet currently presented
- grant_id  out  3  index of the source of the presented packet
- pkt_sent_cnt  out  CNT_BITS  packets accepted by the BFT
- stall_err  out  1  sticky; retry limit reached

Behaviour:
- Reset (asynchronous, active-high). While reset is asserted:
  - dout=0, grant_id=0, pkt_sent_cnt=0, stall_err=0.
  - rr_ptr=NUM_SRC-1, so source 0 has first priority; retry_cnt=0; state=IDLE.
  - src_ready=0.
- States:
  - IDLE: output register empty, dout=0.
  - SEND: valid packet presented.
- Definitions:
  - out_free = (state==IDLE) || (state==SEND && !resend).
  - pick = first i with src_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
  - src_ready[pick] = out_free && any(src_valid); all other src_ready bits are 0.
- Transfer: occurs when src_valid[i] && src_ready[i]. On the next edge:
  - dout <= {1'b1, src_pkt_i[PACKET_BITS-2:0]} (valid bit forced to 1).
  - grant_id <= i; rr_ptr <= i; retry_cnt <= 0; state <= SEND.
  - Latency from source handshake to BFT presentation is 1 cycle.
- SEND && resend:
  - dout, grant_id and rr_ptr hold.
  - retry_cnt increments, saturating at MAX_RETRY.
  - When retry_cnt reaches MAX_RETRY, stall_err <= 1. stall_err stays set until reset.
  - Packets are never dropped.
- SEND && !resend: the packet is consumed.
  - pkt_sent_cnt increments, wrapping at 2^CNT_BITS.
  - If a transfer occurs in the same cycle, the next packet loads back-to-back with no bubble.
  - Otherwise dout <= 0 and state <= IDLE.
- IDLE: resend is ignored; pkt_sent_cnt does not change.
- rr_ptr advances only on a transfer, never on a resend cycle.
- Wrap-around: with rr_ptr=NUM_SRC-1, source 0 has highest priority.
- src_valid may drop without a handshake; the arbiter re-picks every cycle. A source must hold src_pkt stable only during its own handshake cycle.
- A reset asserted during SEND/retry discards the held packet; no partial state remains.
- A valid bit set in src_pkt while src_valid=0 is ignored.

Decomposition:
- Shared package leaf_pkg:
  - PACKET_BITS/PAYLOAD_BITS/NUM_LEAF_BITS/NUM_PORT_BITS defaults.
  - VLD_BIT index.
  - State encoding for IDLE/SEND.
- Sub-module leaf_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_SRC], ptr. Outputs: one-hot gnt, index, any.
  - Reused by future leaf-side arbiters.

Test Plan:
1. Single source 1 sends packets A, B with resend=0 → dout=A at cycle+1 with MSB=1, then B; grant_id=1; pkt_sent_cnt=2; src_ready[1] high each cycle.
2. Sources 0, 1, 2 continuously valid, resend=0 → grant sequence 0,1,2,0,1,2; each dout tagged correctly; no idle cycles.
3. Packet P presented, resend held 3 cycles → dout=P for 4 cycles; src_ready=0 during the 3 resend cycles; rr_ptr unchanged; pkt_sent_cnt +1 only after resend drops.
4. MAX_RETRY=4, resend held 6 cycles → stall_err=1 after the 4th resend; remains 1 after resend drops and the packet completes.
5. rr_ptr=2 (NUM_SRC=4), only sources 0 and 3 valid → source 3 granted, then source 0 (wrap).
6. Reset asserted mid-retry, asynchronously between edges → dout=0, src_ready=0 and counters 0 immediately; after release, source 0 has first priority.

Source files
------------

// File: rtl/leaf_pkg.sv
// -----------------------------------------------------------------------------
// leaf_pkg
// Shared definitions for leaf-side blocks that talk to the BFT.
//   - Default packet geometry: 1 valid bit, destination/source leaf and port
//     addresses, payload.
//   - Index of the packet valid bit.
//   - State encoding for the leaf output arbiter.
// -----------------------------------------------------------------------------
package leaf_pkg;

  localparam int NUM_LEAF_BITS = 8;
  localparam int NUM_PORT_BITS = 8;
  localparam int PAYLOAD_BITS  = 64;

  // {valid, dst_leaf, dst_port, src_leaf, src_port, payload}
  localparam int PACKET_BITS = 1 + 2 * (NUM_LEAF_BITS + NUM_PORT_BITS) + PAYLOAD_BITS;
  localparam int VLD_BIT     = PACKET_BITS - 1;

  // Index width used by leaf arbiters; covers up to 8 requesters.
  localparam int SRC_IDX_BITS = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,  // output register empty
    ST_SEND = 1'b1   // valid packet presented to the BFT
  } arb_state_e;

endpackage : leaf_pkg

// File: rtl/leaf_rr_pick.sv
// -----------------------------------------------------------------------------
// leaf_rr_pick
// Combinational round-robin picker. Searches req starting at ptr+1 and
// wrapping modulo NUM_SRC; the requester at ptr itself is checked last.
//
// Ports:
//   req  in  NUM_SRC       request vector
//   ptr  in  SRC_IDX_BITS  index of the most recent winner
//   gnt  out NUM_SRC       one-hot (or zero) grant
//   idx  out SRC_IDX_BITS  index of the granted requester (0 when none)
//   any  out 1             at least one request present
// -----------------------------------------------------------------------------
module leaf_rr_pick
  import leaf_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]      req,
  input  logic [SRC_IDX_BITS-1:0] ptr,
  output logic [NUM_SRC-1:0]      gnt,
  output logic [SRC_IDX_BITS-1:0] idx,
  output logic                    any
);

  logic found;

  // NOTE: every output of this block gets a default before the search loop,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int c;
      c = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = SRC_IDX_BITS'(c);
      end
    end
    any = found;
  end

endmodule : leaf_rr_pick

// File: rtl/leaf_out_arbiter.sv
// -----------------------------------------------------------------------------
// leaf_out_arbiter
// Shares the single leaf-to-BFT output packet port among NUM_SRC requesters.
// Winners are chosen round-robin and registered onto dout_leaf_interface2bft
// with the valid bit forced high. While the BFT asserts resend the registered
// packet is held; consecutive resends are counted and stall_err latches once
// MAX_RETRY is reached.
//
// Ports:
//   clk                      in  1                     clock
//   reset                    in  1                     async, active-high
//   src_pkt                  in  NUM_SRC*PACKET_BITS   packet i at [i*PACKET_BITS +: PACKET_BITS]
//   src_valid                in  NUM_SRC               requester has a packet
//   src_ready                out NUM_SRC               one-hot-or-zero accept (combinational)
//   dout_leaf_interface2bft  out PACKET_BITS           registered packet to the BFT
//   resend                   in  1                     BFT rejected the presented packet
//   grant_id                 out 3                     source of the presented packet
//   pkt_sent_cnt             out CNT_BITS              packets accepted by the BFT
//   stall_err                out 1                     sticky retry-limit flag
// -----------------------------------------------------------------------------
module leaf_out_arbiter
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS = leaf_pkg::PACKET_BITS,
  parameter int NUM_SRC     = 4,
  parameter int MAX_RETRY   = 255,
  parameter int CNT_BITS    = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC*PACKET_BITS-1:0] src_pkt,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [PACKET_BITS-1:0]         dout_leaf_interface2bft,
  input  logic                           resend,
  output logic [SRC_IDX_BITS-1:0]        grant_id,
  output logic [CNT_BITS-1:0]            pkt_sent_cnt,
  output logic                           stall_err
);

  localparam int RETRY_BITS = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_BITS-1:0] RETRY_MAX = RETRY_BITS'(MAX_RETRY);

  arb_state_e              state_q, state_d;
  logic [PACKET_BITS-1:0]  dout_q, dout_d;
  logic [SRC_IDX_BITS-1:0] grant_q, grant_d;
  logic [SRC_IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [RETRY_BITS-1:0]   retry_q, retry_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic                    stall_q, stall_d;

  logic [NUM_SRC-1:0]      pick_gnt;
  logic [SRC_IDX_BITS-1:0] pick_idx;
  logic                    pick_any;
  logic                    out_free;
  logic                    xfer;
  logic [PACKET_BITS-1:0]  load_pkt;

  leaf_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req (src_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The output register can take a new packet when empty, or when the packet
  // currently presented is being accepted this cycle (back-to-back loading).
  // The reset term keeps src_ready low for the whole reset window, since the
  // registers already read as IDLE while reset is held.
  always_comb begin
    out_free  = (state_q == ST_IDLE) || !resend;
    src_ready = (out_free && pick_any && !reset) ? pick_gnt : '0;
    xfer      = |src_ready;
  end

  // Winning packet with its valid bit forced high.
  always_comb begin
    load_pkt = src_pkt[int'(pick_idx)*PACKET_BITS +: PACKET_BITS];
    load_pkt[PACKET_BITS-1] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;

    unique case (state_q)
      ST_IDLE: ;  // resend is ignored while nothing is presented
      ST_SEND: begin
        if (resend) begin
          // Packet is held; only the retry bookkeeping moves.
          if (retry_q != RETRY_MAX) retry_d = retry_q + 1'b1;
          if (retry_d == RETRY_MAX) stall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!xfer) begin
            dout_d  = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // xfer already implies out_free, so a load never overwrites a held packet.
    if (xfer) begin
      dout_d   = load_pkt;
      grant_d  = pick_idx;
      rr_ptr_d = pick_idx;
      retry_d  = '0;
      state_d  = ST_SEND;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dout_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= SRC_IDX_BITS'(NUM_SRC - 1);
      retry_q  <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign grant_id                = grant_q;
  assign pkt_sent_cnt            = cnt_q;
  assign stall_err               = stall_q;

endmodule : leaf_out_arbiter
